// File: rtl/uart_aes_ctrl.sv
// uart_aes_ctrl
//   Command sequencer sitting between a UART byte receiver, an AES-128 core
//   and a UART byte transmitter. Host frames:
//     'K' + 16 bytes : load the 128-bit key (first byte -> [127:120])
//     'P' + 16 bytes : load the plaintext, encrypt, and stream the 16
//                      ciphertext bytes back, MSB byte first
//   A 'P' with no key loaded is answered with the single byte ERR_BYTE.
//
// Ports
//   uart_clock, uart_reset      clock, asynchronous active-high reset
//   rx_data[7:0], rx_valid      receiver byte and level valid (rising edge = new byte)
//   aes_key[127:0]              key register driven to the core
//   aes_plaintext[127:0]        plaintext register driven to the core
//   aes_start                   one-cycle encryption start pulse
//   aes_done, aes_ciphertext    completion pulse and result from the core
//   tx_data[7:0], tx_start      byte to send and one-cycle send request
//   tx_busy                     transmitter busy level
//   key_loaded                  a complete key frame has been accepted
//   frame_error                 one-cycle pulse: inter-byte timeout or dropped byte
//   ctrl_busy                   sequencer is not idle
module uart_aes_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000,
  parameter logic [7:0]  CMD_KEY        = 8'h4B,
  parameter logic [7:0]  CMD_PT         = 8'h50,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic         uart_clock,
  input  logic         uart_reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ciphertext,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         key_loaded,
  output logic         frame_error,
  output logic         ctrl_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_PT, S_START, S_WAIT_AES,
    S_TX_SEND, S_TX_GAP, S_TX_WAIT, S_SEND_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          rx_valid_q;
  logic [127:0]  shadow_q, shadow_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [23:0]   to_q, to_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  pt_q, pt_d;
  logic          key_loaded_q, key_loaded_d;
  logic [127:0]  tx_q, tx_d;
  logic [3:0]    tx_idx_q, tx_idx_d;
  logic          new_byte;

  // One byte per rising edge of the receiver's level-valid.
  assign new_byte = rx_valid & ~rx_valid_q;

  // NOTE: the wide data registers are plain flops, so they are reset along
  // with the control state; nothing here is a RAM that would forbid it.
  always_ff @(posedge uart_clock or posedge uart_reset) begin
    if (uart_reset) begin
      state_q      <= S_IDLE;
      rx_valid_q   <= 1'b0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      to_q         <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      key_loaded_q <= 1'b0;
      tx_q         <= '0;
      tx_idx_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      rx_valid_q   <= rx_valid;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      key_loaded_q <= key_loaded_d;
      tx_q         <= tx_d;
      tx_idx_q     <= tx_idx_d;
    end
  end

  always_comb begin
    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips an assignment would infer a latch.
    state_d      = state_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    key_d        = key_q;
    pt_d         = pt_q;
    key_loaded_d = key_loaded_q;
    tx_d         = tx_q;
    tx_idx_d     = tx_idx_q;
    aes_start    = 1'b0;
    tx_start     = 1'b0;
    frame_error  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counters are held clear here so each frame starts from zero.
        cnt_d = '0;
        to_d  = '0;
        if (new_byte) begin
          if (rx_data == CMD_KEY) begin
            state_d = S_LOAD_KEY;
          end else if (rx_data == CMD_PT) begin
            if (key_loaded_q) begin
              state_d = S_LOAD_PT;
            end else begin
              // Reuse the TX shifter: one byte, index preset to the last slot.
              tx_d     = {ERR_BYTE, 120'd0};
              tx_idx_d = 4'd15;
              state_d  = S_SEND_ERR;
            end
          end
        end
      end

      S_LOAD_KEY, S_LOAD_PT: begin
        if (new_byte) begin
          shadow_d = {shadow_q[119:0], rx_data};
          cnt_d    = cnt_q + 4'd1;
          to_d     = '0;
          if (cnt_q == 4'd15) begin
            if (state_q == S_LOAD_KEY) begin
              key_d        = shadow_d;
              key_loaded_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              pt_d    = shadow_d;
              state_d = S_START;
            end
          end
        end else if (to_q == TIMEOUT_CYCLES - 24'd1) begin
          // Abandon the partial frame; the shadow is overwritten by the next one.
          frame_error = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else begin
          to_d = to_q + 24'd1;
        end
      end

      S_START: begin
        aes_start = 1'b1;
        state_d   = S_WAIT_AES;
      end

      S_WAIT_AES: begin
        if (aes_done) begin
          tx_d     = aes_ciphertext;
          tx_idx_d = '0;
          state_d  = S_TX_SEND;
        end
      end

      S_TX_SEND, S_SEND_ERR: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_TX_GAP;
        end
      end

      // The transmitter needs a cycle to raise tx_busy after tx_start.
      S_TX_GAP: state_d = S_TX_WAIT;

      S_TX_WAIT: begin
        if (!tx_busy) begin
          if (tx_idx_q == 4'd15) begin
            state_d = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 4'd1;
            tx_d     = {tx_q[119:0], 8'd0};
            state_d  = S_TX_SEND;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while the sequencer cannot accept them are dropped.
    if (new_byte && !(state_q inside {S_IDLE, S_LOAD_KEY, S_LOAD_PT}))
      frame_error = 1'b1;
  end

  assign aes_key       = key_q;
  assign aes_plaintext = pt_q;
  assign key_loaded    = key_loaded_q;
  assign tx_data       = tx_q[127:120];
  assign ctrl_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_aes_ctrl.sv
// tb_uart_aes_ctrl
//   Randomized bench for uart_aes_ctrl. Frames are built from byte arrays,
//   the host-side expectations (key, plaintext, reply byte stream) are kept
//   as plain vectors and queues, and simple AES/TX responders model the
//   neighbouring blocks.
module tb_uart_aes_ctrl;

  localparam logic [23:0] TO       = 24'd100;
  localparam logic [7:0]  CMD_KEY  = 8'h4B;
  localparam logic [7:0]  CMD_PT   = 8'h50;
  localparam logic [7:0]  ERR_BYTE = 8'hEE;

  logic         uart_clock = 1'b0;
  logic         uart_reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] aes_key, aes_plaintext, aes_ciphertext;
  logic         aes_start, aes_done;
  logic [7:0]   tx_data;
  logic         tx_start, tx_busy;
  logic         key_loaded, frame_error, ctrl_busy;

  uart_aes_ctrl #(.TIMEOUT_CYCLES(TO), .CMD_KEY(CMD_KEY), .CMD_PT(CMD_PT), .ERR_BYTE(ERR_BYTE)) dut (
    .uart_clock(uart_clock), .uart_reset(uart_reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_start(aes_start),
    .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .key_loaded(key_loaded), .frame_error(frame_error), .ctrl_busy(ctrl_busy)
  );

  always #5 uart_clock = ~uart_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- observation ----------------
  logic [7:0]   tx_log[$];
  int           n_tx = 0, n_aes_start = 0, n_ferr = 0;
  int           aes_delay = 5;
  logic [127:0] next_ct, exp_key, exp_pt;
  bit           tx_chk_en = 1'b1;

  always @(negedge uart_clock) begin
    if (!uart_reset) begin
      if (tx_start) begin
        n_tx++;
        tx_log.push_back(tx_data);
      end
      if (frame_error) n_ferr++;
      if (aes_start)   n_aes_start++;
    end
  end

  // AES core model: checks the operands at start, answers after aes_delay.
  initial begin
    aes_done       = 1'b0;
    aes_ciphertext = '0;
    forever begin
      @(negedge uart_clock);
      if (aes_start && !uart_reset) begin
        check("key_at_start", aes_key, exp_key);
        check("pt_at_start", aes_plaintext, exp_pt);
        repeat (aes_delay) @(posedge uart_clock);
        #1 aes_done = 1'b1;
        aes_ciphertext = next_ct;
        @(posedge uart_clock);
        #1 aes_done = 1'b0;
        aes_ciphertext = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Transmitter model: busy for a random time, tx_data must hold meanwhile.
  logic [7:0] tx_hold_byte;
  int         tx_busy_len;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge uart_clock);
      if (tx_start && !uart_reset) begin
        tx_hold_byte = tx_data;
        tx_busy_len  = $urandom_range(2, 8);
        @(posedge uart_clock);
        #1 tx_busy = 1'b1;
        repeat (tx_busy_len) begin
          @(negedge uart_clock);
          if (tx_chk_en && !uart_reset) check("tx_data_hold", tx_data, tx_hold_byte);
        end
        @(posedge uart_clock);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge uart_clock);
    #1 rx_data = b;
    rx_valid = 1'b1;
    repeat (hold) @(posedge uart_clock);
    #1 rx_valid = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(posedge uart_clock);
  endtask

  // Sends one byte and returns right after the edge that captures it.
  task automatic capture_byte(input logic [7:0] b);
    @(posedge uart_clock);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge uart_clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] data,
                            input bit chk_start, input int long_idx);
    logic [7:0] b;
    send_byte(cmd, $urandom_range(1, 3), $urandom_range(0, 4));
    for (int i = 0; i < 16; i++) begin
      b = data[127 - 8*i -: 8];
      if (i == 15 && chk_start) begin
        capture_byte(b);
        @(negedge uart_clock);
        check("aes_start_latency", aes_start, 1'b1);
      end else begin
        send_byte(b, (i == long_idx) ? 50 : $urandom_range(1, 3), $urandom_range(0, 4));
      end
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (n_tx < n && c < budget) begin
      @(negedge uart_clock);
      c++;
    end
    check("tx_count_reached", n_tx, n);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (ctrl_busy && c < budget) begin
      @(negedge uart_clock);
      c++;
    end
    check("back_to_idle", ctrl_busy, 1'b0);
  endtask

  task automatic check_reply(input logic [127:0] ct);
    check("tx_reply_len", tx_log.size(), 16);
    for (int i = 0; i < 16 && i < tx_log.size(); i++)
      check($sformatf("tx_byte%0d", i), tx_log[i], ct[127 - 8*i -: 8]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key"}, aes_key, '0);
    check({tag, "_pt"}, aes_plaintext, '0);
    check({tag, "_ctl"}, {aes_start, tx_data, tx_start, key_loaded, frame_error, ctrl_busy}, '0);
  endtask

  task automatic do_reset();
    uart_reset = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    repeat (3) @(posedge uart_clock);
    #1 uart_reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  int base_tx, base_ferr, base_start;
  logic [127:0] k1, k2;

  initial begin
    do_reset();
    @(negedge uart_clock);
    check_outputs_zero("reset");

    // 1: key load
    exp_key = 128'h000102030405060708090A0B0C0D0E0F;
    send_frame(CMD_KEY, exp_key, 1'b0, -1);
    repeat (3) @(negedge uart_clock);
    check("t1_key", aes_key, exp_key);
    check("t1_key_loaded", key_loaded, 1'b1);
    check("t1_no_tx", n_tx, 0);
    check("t1_no_ferr", n_ferr, 0);
    check("t1_idle", ctrl_busy, 1'b0);

    // 2: encrypt, reply stream in order
    exp_pt    = 128'h00112233445566778899AABBCCDDEEFF;
    next_ct   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    aes_delay = 7;
    tx_log.delete();
    base_tx = n_tx;
    send_frame(CMD_PT, exp_pt, 1'b1, -1);
    wait_tx(base_tx + 16, 800);
    check_reply(next_ct);
    wait_idle(100);
    check("t2_one_start", n_aes_start, 1);
    check("t2_pt_reg", aes_plaintext, exp_pt);

    // 3: 'P' without key -> single error byte
    do_reset();
    tx_log.delete();
    base_tx = n_tx;
    base_start = n_aes_start;
    send_byte(CMD_PT, 2, 0);
    wait_tx(base_tx + 1, 100);
    check("t3_err_byte", (tx_log.size() > 0) ? tx_log[0] : 8'h00, ERR_BYTE);
    wait_idle(100);
    repeat (20) @(negedge uart_clock);
    check("t3_single_tx", n_tx, base_tx + 1);
    check("t3_no_start", n_aes_start, base_start);
    check("t3_no_key", key_loaded, 1'b0);

    // 4: timeout mid key frame
    k1 = {$urandom, $urandom, $urandom, $urandom};
    exp_key = k1;
    send_frame(CMD_KEY, k1, 1'b0, -1);
    repeat (2) @(negedge uart_clock);
    check("t4_k1", aes_key, k1);
    base_ferr = n_ferr;
    send_byte(CMD_KEY, 1, 1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, $urandom_range(0, 3));
    capture_byte(8'($urandom));
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge uart_clock);
      if (i == int'(TO) - 2) check("t4_no_early_timeout", frame_error, 1'b0);
      if (i == int'(TO) - 1) check("t4_timeout_pulse", frame_error, 1'b1);
    end
    @(negedge uart_clock);
    check("t4_idle", ctrl_busy, 1'b0);
    check("t4_one_ferr", n_ferr, base_ferr + 1);
    check("t4_key_kept", aes_key, k1);
    check("t4_key_loaded_kept", key_loaded, 1'b1);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    exp_key = k2;
    send_frame(CMD_KEY, k2, 1'b0, -1);
    repeat (2) @(negedge uart_clock);
    check("t4_k2", aes_key, k2);

    // 5: long rx_valid level, overrun during WAIT_AES
    exp_pt    = {$urandom, $urandom, $urandom, $urandom};
    next_ct   = {$urandom, $urandom, $urandom, $urandom};
    aes_delay = 40;
    tx_log.delete();
    base_tx = n_tx;
    base_start = n_aes_start;
    base_ferr = n_ferr;
    send_frame(CMD_PT, exp_pt, 1'b1, 3);
    send_byte(CMD_KEY, 1, 0);
    repeat (3) @(negedge uart_clock);
    check("t5_overrun_ferr", n_ferr, base_ferr + 1);
    wait_tx(base_tx + 16, 800);
    check_reply(next_ct);
    wait_idle(100);
    check("t5_one_start", n_aes_start, base_start + 1);
    check("t5_key_unchanged", aes_key, k2);

    // 6: reset during TX_WAIT of byte 7
    exp_pt    = {$urandom, $urandom, $urandom, $urandom};
    next_ct   = {$urandom, $urandom, $urandom, $urandom};
    aes_delay = 3;
    base_tx = n_tx;
    base_start = n_aes_start;
    send_frame(CMD_PT, exp_pt, 1'b0, -1);
    wait_tx(base_tx + 8, 800);
    repeat (2) @(negedge uart_clock);
    tx_chk_en = 1'b0;
    #2 uart_reset = 1'b1;
    #1 check_outputs_zero("t6_in_reset");
    repeat (3) @(posedge uart_clock);
    #1 uart_reset = 1'b0;
    repeat (200) @(negedge uart_clock);
    check("t6_no_more_tx", n_tx, base_tx + 8);
    check("t6_no_more_start", n_aes_start, base_start + 1);
    check_outputs_zero("t6_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
